// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; both run on operand magnitudes.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       op_q, op_d;
    // Multiply: {upper partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mult_next;

    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic               fits;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        a_neg = op[0] & a[WIDTH-1];
        b_neg = op[0] & b[WIDTH-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;
    end

    // One multiplier bit per cycle; the carry lands in the top bit of the shifted accumulator.
    always_comb begin
        addend    = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
        msum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        mult_next = {msum, acc_q[WIDTH-1:1]};
    end

    // Shifted remainder can reach WIDTH+1 bits, but the kept difference always fits in WIDTH.
    always_comb begin
        shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        fits    = shifted >= {1'b0, opnd_q};
        diff    = shifted[WIDTH-1:0] - opnd_q;
        if (fits) begin
            div_next = {diff, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod = (op_q[0] && neg_res_q) ? -acc_q : acc_q;
        quo  = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d      = op;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = (b == '0);
                    count_d   = CW'(WIDTH - 1);
                    busy_d    = 1'b1;
                    state_d   = StCalc;
                    if (op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                end else begin
                    if (mthi) hi_d = wd;
                    if (mtlo) lo_d = wd;
                end
            end
            StCalc: begin
                acc_d   = op_q[1] ? div_next : mult_next;
                count_d = count_q - 1'b1;
                if (count_q == '0) state_d = StFix;
            end
            StFix: begin
                if (op_q[1]) begin
                    // Divide by zero leaves |a| as remainder, so hi already equals a after sign fix.
                    lo_d = div0_q ? {WIDTH{1'b1}} : (neg_res_q ? -quo : quo);
                    hi_d = neg_rem_q ? -rem : rem;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers. It sits beside the single-cycle ALU in the datapath and executes MULT, MULTU, DIV and DIVU over multiple cycles. It uses a start/busy/done handshake so the controller can stall dependent MFHI/MFLO instructions. Data width is parametrised; HI/LO can also be written directly for MTHI/MTLO.

## Interface
- WIDTH, 32, operand and HI/LO width (even, ≥4)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
- a  in  WIDTH  multiplicand / dividend (rs); sampled with start
- b  in  WIDTH  multiplier / divisor (rt); sampled with start
- mthi  in  1  write wd into hi; effective only in IDLE without start
- mtlo  in  1  write wd into lo; same rule as mthi
- wd  in  WIDTH  MTHI/MTLO data
- hi  out  WIDTH  HI register (product high / remainder)
- lo  out  WIDTH  LO register (product low / quotient)
- busy  out  1  operation in progress (registered)
- done  out  1  one-cycle pulse; hi/lo hold the new result

## Operation
- FSM states: IDLE, CALC, FIX. Reset → IDLE. All outputs reset to 0.
- IDLE with start=1: latch op and magnitudes of a and b. Signed ops take the two's-complement magnitude; unsigned ops take the raw value. Record the result signs and the divide-by-zero flag (b==0). Load count=WIDTH−1, go to CALC, busy←1.
- CALC, multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division. Each cycle shift {rem,quo} left by 1 and trial-subtract the divisor. If there is no borrow, keep the difference and set the quotient bit.
- CALC decrements count. When count==0, the next state is FIX.
- FIX, signed multiply: negate the 2·WIDTH product if the operand signs differ.
- FIX, signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- FIX writes hi/lo, sets done←1 and busy←0, and returns to IDLE.
- Divide by zero (DIV or DIVU): lo ← all ones, hi ← a as sampled, no trap.
- Signed overflow (DIV of most-negative by −1): lo ← most-negative value, hi ← 0. This falls out of the magnitude algorithm and needs no special case.
- start asserted while busy is ignored; no queueing.
- mthi/mtlo asserted while busy are ignored.
- start together with mthi/mtlo in IDLE: start wins and the write is dropped.
- mthi and mtlo together are both performed.
- hi/lo keep their old values throughout CALC. They change only in FIX or on an accepted MTHI/MTLO.

## Timing
- Edge E0 samples start. busy is high for cycles E0..E(WIDTH+1), i.e. WIDTH+1 cycles.
- Edge E(WIDTH+1) updates hi/lo and asserts done for exactly one cycle; busy is already low in that cycle.
- A new start is accepted at E(WIDTH+1)+1 at the earliest: the cycle done is high counts as IDLE, so start may be issued then.
- Latency is fixed at WIDTH+1 cycles for all ops and operand values, including divide by zero.
- MTHI/MTLO: written at the sampling edge; the new value is visible the following cycle.
- Reset asserted mid-operation: immediately returns to IDLE with hi=lo=0, busy=done=0; the partial result is discarded.
- Every operand is latched at start. Changes to a/b/op during CALC have no effect.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. done occurs exactly 33 cycles after the start edge. busy is high 33 cycles.
- MULT a=−3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed divides:
  - DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0x00000000.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x00001234, with the same latency of 33 cycles.
- Handshake conflicts:
  - start a MULTU 2×3; pulse start with DIVU operands at cycle 5 → ignored, result hi=0, lo=6.
  - mtlo wd=0xAA during busy → ignored.
  - mtlo in IDLE → lo=0xAA next cycle.
- Assert reset at cycle 10 of a DIV → hi=lo=0, busy=0 immediately. A following MULTU 4×4 → lo=0x10 after 33 cycles.
